// File: rtl/if_id_skid_pkg.sv
// Shared widths and the skid occupancy encoding for the IF/ID boundary.
// Payload layout, MSB first: {pc, instr, prdt_taken, pc_misalign, bus_err}.
`ifndef PC_WIDTH
`define PC_WIDTH 64
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif
`ifndef IF_ID_PAYLOAD_W
`define IF_ID_PAYLOAD_W (PC_W+INSTR_W+3)
`endif

package if_id_skid_pkg;

    // OCC2 means both the output and the skid register hold a bundle.
    typedef enum logic [1:0] {
        OCC0 = 2'd0,
        OCC1 = 2'd1,
        OCC2 = 2'd2
    } occ_e;

endpackage

// File: rtl/if_id_skid_pipe_dffr.sv
// Enable-loaded register with synchronous active-high clear, used for the
// output and skid payload slots of if_id_skid.
module pipe_dffr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (en) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/if_id_skid.sv
// IF/ID boundary: 2-entry skid buffer with a registered ifu_ready_o and EX flush.
// Optional IF_ID_PERF_CNT_EN adds decode-stall and flush event counters.
`ifndef PC_WIDTH
`define PC_WIDTH 64
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif
`ifndef IF_ID_PAYLOAD_W
`define IF_ID_PAYLOAD_W (PC_W+INSTR_W+3)
`endif

module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int                 PC_W      = `PC_WIDTH,
    parameter int                 INSTR_W   = `INSTR_WIDTH,
    parameter logic [INSTR_W-1:0] NOP_INSTR = `INSTR_NOP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               ifu_valid_i,
    output logic               ifu_ready_o,
    input  logic [PC_W-1:0]    ifu_pc_i,
    input  logic [INSTR_W-1:0] ifu_instr_i,
    input  logic               ifu_prdt_taken_i,
    input  logic               ifu_pc_misalign_i,
    input  logic               ifu_bus_err_i,
    output logic               id_valid_o,
    input  logic               id_ready_i,
    output logic [PC_W-1:0]    id_pc_o,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic               id_prdt_taken_o,
    output logic               id_pc_misalign_o,
    output logic               id_bus_err_o
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [63:0]        perf_stall_cnt_o,
    output logic [63:0]        perf_flush_cnt_o
`endif
);

    localparam int PAY_W = `IF_ID_PAYLOAD_W;

    // A faulting fetch must never reach decode as a real instruction.
    function automatic logic [PAY_W-1:0] sanitise(
        input logic [PC_W-1:0]    pc,
        input logic [INSTR_W-1:0] instr,
        input logic               prdt,
        input logic               mis,
        input logic               berr
    );
        logic fault;
        fault = mis | berr;
        return {pc, (fault ? NOP_INSTR : instr), (prdt & ~fault), mis, berr};
    endfunction

    occ_e             state_q, state_d;
    logic             ready_q, ready_d;
    logic             out_en, skd_en;
    logic [PAY_W-1:0] cap_pay, out_d, out_pay_q, skd_pay_q;
    logic             acc, pop;

    assign ifu_ready_o = ready_q;
    assign id_valid_o  = (state_q != OCC0);
    assign acc         = ifu_valid_i & ready_q;
    assign pop         = id_valid_o & id_ready_i;
    assign cap_pay     = sanitise(ifu_pc_i, ifu_instr_i, ifu_prdt_taken_i,
                                  ifu_pc_misalign_i, ifu_bus_err_i);

    always_comb begin
        state_d = state_q;
        out_en  = 1'b0;
        skd_en  = 1'b0;
        out_d   = cap_pay;
        if (flush_i) begin
            state_d = OCC0;
        end else begin
            unique case (state_q)
                OCC0: begin
                    if (acc) begin
                        out_en  = 1'b1;
                        state_d = OCC1;
                    end
                end
                OCC1: begin
                    if (acc && pop) begin
                        out_en = 1'b1;
                    end else if (acc) begin
                        skd_en  = 1'b1;
                        state_d = OCC2;
                    end else if (pop) begin
                        state_d = OCC0;
                    end
                end
                OCC2: begin
                    if (pop) begin
                        out_en  = 1'b1;
                        out_d   = skd_pay_q;
                        state_d = OCC1;
                    end
                end
                default: state_d = OCC0;
            endcase
        end
        // Ready depends only on next-cycle state, so no id_ready_i -> ifu_ready_o path.
        ready_d = (state_d != OCC2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OCC0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    pipe_dffr #(.W(PAY_W)) u_out_reg (
        .clk (clk),
        .rst (rst),
        .en  (out_en),
        .d   (out_d),
        .q   (out_pay_q)
    );

    pipe_dffr #(.W(PAY_W)) u_skd_reg (
        .clk (clk),
        .rst (rst),
        .en  (skd_en),
        .d   (cap_pay),
        .q   (skd_pay_q)
    );

    assign {id_pc_o, id_instr_o, id_prdt_taken_o, id_pc_misalign_o, id_bus_err_o} = out_pay_q;

`ifdef IF_ID_PERF_CNT_EN
    logic [63:0] stall_cnt_q, stall_cnt_d;
    logic [63:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {63'd0, (id_valid_o & ~id_ready_i)};
        flush_cnt_d = flush_cnt_q + {63'd0, (flush_i & id_valid_o)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Scoreboard bench for if_id_skid: a 2-deep FIFO reference model checked every cycle
// against the DUT handshake and payload, with directed scenarios then random traffic.
module tb_if_id_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        ifu_valid_i;
    logic        ifu_ready_o;
    logic [63:0] ifu_pc_i;
    logic [31:0] ifu_instr_i;
    logic        ifu_prdt_taken_i;
    logic        ifu_pc_misalign_i;
    logic        ifu_bus_err_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [63:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_prdt_taken_o;
    logic        id_pc_misalign_o;
    logic        id_bus_err_o;
`ifdef IF_ID_PERF_CNT_EN
    logic [63:0] perf_stall_cnt_o;
    logic [63:0] perf_flush_cnt_o;
    longint unsigned m_stall = 0;
    longint unsigned m_flush = 0;
`endif

    always #5 clk = ~clk;

    if_id_skid dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush_i),
        .ifu_valid_i       (ifu_valid_i),
        .ifu_ready_o       (ifu_ready_o),
        .ifu_pc_i          (ifu_pc_i),
        .ifu_instr_i       (ifu_instr_i),
        .ifu_prdt_taken_i  (ifu_prdt_taken_i),
        .ifu_pc_misalign_i (ifu_pc_misalign_i),
        .ifu_bus_err_i     (ifu_bus_err_i),
        .id_valid_o        (id_valid_o),
        .id_ready_i        (id_ready_i),
        .id_pc_o           (id_pc_o),
        .id_instr_o        (id_instr_o),
        .id_prdt_taken_o   (id_prdt_taken_o),
        .id_pc_misalign_o  (id_pc_misalign_o),
        .id_bus_err_o      (id_bus_err_o)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .perf_stall_cnt_o  (perf_stall_cnt_o),
        .perf_flush_cnt_o  (perf_flush_cnt_o)
`endif
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        pt;
        logic        mis;
        logic        be;
    } bundle_t;

    bundle_t exp_q[$];
    int      errors = 0;
    int      checks = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: compares DUT state against the model, then applies pop/flush.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (rst) begin
                exp_q.delete();
`ifdef IF_ID_PERF_CNT_EN
                m_stall = 0;
                m_flush = 0;
`endif
            end else begin
                chk("ifu_ready", {63'd0, ifu_ready_o}, {63'd0, (exp_q.size() < 2)});
                chk("id_valid", {63'd0, id_valid_o}, {63'd0, (exp_q.size() > 0)});
                if (exp_q.size() > 0) begin
                    chk("id_pc", id_pc_o, exp_q[0].pc);
                    chk("id_instr", {32'd0, id_instr_o}, {32'd0, exp_q[0].instr});
                    chk("id_flags", {61'd0, id_prdt_taken_o, id_pc_misalign_o, id_bus_err_o},
                        {61'd0, exp_q[0].pt, exp_q[0].mis, exp_q[0].be});
                end
`ifdef IF_ID_PERF_CNT_EN
                chk("perf_stall", perf_stall_cnt_o, m_stall);
                chk("perf_flush", perf_flush_cnt_o, m_flush);
                if (exp_q.size() > 0 && !id_ready_i) m_stall++;
                if (exp_q.size() > 0 && flush_i) m_flush++;
`endif
                if (exp_q.size() > 0 && id_ready_i) void'(exp_q.pop_front());
                if (flush_i) exp_q.delete();
            end
        end
    end

    // One cycle of stimulus; an accepted bundle is pushed as the decoder should see it.
    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                         input logic pt, input logic mis, input logic be,
                         input logic rdy, input logic fl, output logic accepted);
        bundle_t b;
        @(posedge clk);
        #1;
        ifu_valid_i       = v;
        ifu_pc_i          = pc;
        ifu_instr_i       = ins;
        ifu_prdt_taken_i  = pt;
        ifu_pc_misalign_i = mis;
        ifu_bus_err_i     = be;
        id_ready_i        = rdy;
        flush_i           = fl;
        #4;
        accepted = v & ifu_ready_o & ~fl;
        if (accepted) begin
            b.pc    = pc;
            b.instr = (mis | be) ? 32'h0000_0013 : ins;
            b.pt    = pt & ~(mis | be);
            b.mis   = mis;
            b.be    = be;
            exp_q.push_back(b);
        end
    endtask

    task automatic idle(input logic rdy, input int n);
        logic a;
        for (int i = 0; i < n; i++) drive(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0, rdy, 1'b0, a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        a;
        int          tries;
        logic [63:0] pc_ctr;
        rst = 1'b1;
        flush_i = 1'b0; ifu_valid_i = 1'b0; ifu_pc_i = '0; ifu_instr_i = '0;
        ifu_prdt_taken_i = 1'b0; ifu_pc_misalign_i = 1'b0; ifu_bus_err_i = 1'b0;
        id_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", {63'd0, id_valid_o}, 64'd0);
        chk("rst_ready", {63'd0, ifu_ready_o}, 64'd1);
        chk("rst_pc", id_pc_o, 64'd0);
        chk("rst_instr", {32'd0, id_instr_o}, 64'd0);
        rst = 1'b0;

        // Streaming at full rate.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 64'h1000 + 64'(4 * i), 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a);
        idle(1'b1, 2);

        // Backpressure: two fill the buffer, the third is held off until release.
        drive(1'b1, 64'h2000, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a);
        drive(1'b1, 64'h2004, 32'h201, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 64'h2008, 32'h202, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a);
        chk("bp_held", {63'd0, a}, 64'd0);
        tries = 0;
        do begin
            drive(1'b1, 64'h2008, 32'h202, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a);
            tries++;
        end while (!a && tries < 10);
        chk("bp_accept", {63'd0, a}, 64'd1);
        idle(1'b1, 3);

        // Flush at full occupancy with a bundle offered.
        drive(1'b1, 64'h2100, 32'h210, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a);
        drive(1'b1, 64'h2104, 32'h211, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a);
        drive(1'b1, 64'h3000, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a);
        idle(1'b1, 2);
        // Flush at occupancy 1 while an accept and a pop happen.
        drive(1'b1, 64'h3100, 32'h310, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a);
        drive(1'b1, 64'h3104, 32'h311, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a);
        chk("flush_discard", {63'd0, a}, 64'd0);
        idle(1'b1, 2);

        // Fault sanitising.
        drive(1'b1, 64'h4000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, a);
        drive(1'b1, 64'h4002, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, a);
        drive(1'b1, 64'h4008, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, a);
        idle(1'b1, 3);

        // Randomised traffic.
        pc_ctr = 64'h8000;
        for (int i = 0; i < 2000; i++) begin
            logic v, rdy, fl, mis, be;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 19) == 0);
            mis = ($urandom_range(0, 15) == 0);
            be  = ($urandom_range(0, 15) == 0);
            drive(v, pc_ctr, $urandom, 1'($urandom), mis, be, rdy, fl, a);
            if (a) pc_ctr += 64'd4;
        end
        idle(1'b1, 4);
        chk("drained", {63'd0, id_valid_o}, 64'd0);

        @(posedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
